ram_dp_fifo_ctrl: RTL and testbench
===================================

Name: ram_dp_fifo_ctrl

Overview:
Synchronous FIFO controller that uses an external ram_dp_sr_sw instance as its storage.
- Port 0 of the RAM is the write-only push side; port 1 is the read-only pop side.
- Generates all RAM control, address and data-drive signals, and tracks pointers, occupancy, full/empty and overflow/underflow.
- Sits between a producer stream and a consumer stream, directly upstream of the RAM.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM data width.
- ADDR_WIDTH, 8, RAM address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, FIFO capacity in words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push word.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  popped word; valid only when rd_valid=1.
- rd_valid  out  1  pop data valid.
- full  out  1  count==RAM_DEPTH.
- empty  out  1  count==0.
- count  out  ADDR_WIDTH+1  occupancy.
- wr_drop  out  1  one-cycle pulse: push refused.
- rd_drop  out  1  one-cycle pulse: pop refused.
- ram_address_0  out  ADDR_WIDTH  to RAM address_0.
- ram_data_0  inout  DATA_WIDTH  to RAM data_0.
- ram_cs_0, ram_we_0, ram_oe_0  out  1 each  to RAM port 0 controls.
- ram_address_1  out  ADDR_WIDTH  to RAM address_1.
- ram_data_1  inout  DATA_WIDTH  to RAM data_1; never driven by this block.
- ram_cs_1, ram_we_1, ram_oe_1  out  1 each  to RAM port 1 controls.

Behaviour:
- Reset: synchronous, active-low. All of the following are registered and reset to the values given:
  - wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, wr_drop=0, rd_drop=0.
  - Hence empty=1 and full=0 out of reset.
  - RAM contents are not cleared.
- Push handshake:
  - push = wr_en & !full. full is the registered flag.
  - push=1 in cycle N drives ram_cs_0=1, ram_we_0=1, ram_oe_0=0, ram_address_0=wr_ptr, and ram_data_0=wr_data, all combinationally.
  - The RAM writes at the end of cycle N; wr_ptr increments.
  - When push=0: ram_cs_0=0, ram_we_0=0, and ram_data_0 is high-Z.
- Pop handshake:
  - pop = rd_en & !empty.
  - RAM port 1 is held in read mode whenever reset_n=1: ram_cs_1=1, ram_oe_1=1, ram_we_1=0, ram_address_1=rd_ptr.
  - pop in cycle N: rd_ptr increments and rd_valid=1 in cycle N+1. rd_data in N+1 is ram_data_1 passed through, i.e. mem[rd_ptr at N]. Latency is 1 cycle.
  - While reset_n=0: ram_cs_1=0.
- Pointers: ADDR_WIDTH bits, wrap RAM_DEPTH-1 -> 0 with natural modulo.
- Occupancy: count += push - pop. Both in one cycle leaves count unchanged.
- Boundary conditions:
  - Push while full: refused even if pop is in the same cycle. wr_drop=1 next cycle; no RAM write. This guarantees a write and read never target the same address in one cycle.
  - Pop while empty: refused even if push is in the same cycle. rd_drop=1 next cycle, rd_valid=0.
  - Simultaneous push and pop when neither full nor empty: both are accepted.
  - Reset asserted mid-stream: pointers and count clear at that edge. A rd_valid due in the following cycle is suppressed (forced 0). Words left in the RAM are abandoned.
- ram_we_1 is never 1, so the RAM's port-0 write priority is never exercised.

Decomposition:
- Shared package ram_fifo_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Derived RAM_DEPTH and COUNT_WIDTH=ADDR_WIDTH+1.
- One natural sub-module, fifo_ptr: wrapping pointer register with increment enable and synchronous active-low clear, instantiated twice (write and read).
- Occupancy, flag and drop logic stay in the top.
- Bench top instantiates ram_dp_fifo_ctrl plus ram_dp_sr_sw.

Test Plan:
- Reset (ADDR_WIDTH=2, depth 4): hold reset_n=0 for 2 cycles -> count=0, empty=1, full=0, rd_valid=0, ram_cs_0=0, ram_data_0 high-Z.
- Push 0x11,0x22,0x33,0x44 then 5th push 0x55 -> full=1 after 4th, count=4; 5th gives wr_drop=1 for one cycle, count stays 4.
- From full, pop 4 times -> rd_valid each following cycle with rd_data 0x11,0x22,0x33,0x44 in order; empty=1, count=0; an extra pop gives rd_drop=1, rd_valid=0.
- Wrap: push and pop 10 words 0xA0..0xA9, interleaved so count stays 1-2 -> every word returned in order across pointer wrap; no drops.
- Full with simultaneous push 0x66 and pop -> pop returns the oldest word, push dropped (wr_drop=1), count 4->3.
- Empty with simultaneous push 0x77 and pop -> rd_drop=1, count 0->1; next pop returns 0x77.
- Reset asserted one cycle after a pop -> rd_valid stays 0, count=0, empty=1.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared sizing constants for the RAM-backed FIFO controller and its helpers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ram_fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int RAM_DEPTH_DEF   = 1 << ADDR_WIDTH_DEF;
    localparam int COUNT_WIDTH_DEF = ADDR_WIDTH_DEF + 1;

    // Occupancy needs one bit more than an address so that "full" is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_dp_fifo_ctrl_if.sv
// Producer/consumer stream bundle of the RAM-backed FIFO controller.
// Ports: master = stream user (drives wr_en/wr_data/rd_en, sees status and pop data);
//        slave  = FIFO controller (the reverse).
interface ram_dp_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_drop;
    logic                  rd_drop;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, wr_drop, rd_drop
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, wr_drop, rd_drop
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer register: increments on inc, wraps naturally at 2**WIDTH.
// Latency: new value visible the cycle after inc. Clear is synchronous, active-low.
// Ports: clk, clr_n (sync clear), inc (advance), ptr (current value).
module fifo_ptr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_dp_sr_sw.sv
// Dual-port RAM, synchronous read and write, tristate data buses; port 0 write wins.
// Latency: read data driven the cycle after the read request while cs/oe stay high.
// Ports: per port address/data(inout)/cs/we/oe; contents are never initialised.
module ram_dp_sr_sw #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address_0,
    inout  wire  [DATA_WIDTH-1:0] data_0,
    input  logic                  cs_0,
    input  logic                  we_0,
    input  logic                  oe_0,
    input  logic [ADDR_WIDTH-1:0] address_1,
    inout  wire  [DATA_WIDTH-1:0] data_1,
    input  logic                  cs_1,
    input  logic                  we_1,
    input  logic                  oe_1
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] data_0_out;
    logic [DATA_WIDTH-1:0] data_1_out;

    always_ff @(posedge clk) begin
        if (cs_0 && we_0) begin
            mem[address_0] <= data_0;
        end else if (cs_1 && we_1) begin
            mem[address_1] <= data_1;
        end
    end

    always_ff @(posedge clk) begin
        if (cs_0 && !we_0 && oe_0) begin
            data_0_out <= mem[address_0];
        end
    end

    always_ff @(posedge clk) begin
        if (cs_1 && !we_1 && oe_1) begin
            data_1_out <= mem[address_1];
        end
    end

    assign data_0 = (cs_0 && oe_0 && !we_0) ? data_0_out : {DATA_WIDTH{1'bz}};
    assign data_1 = (cs_1 && oe_1 && !we_1) ? data_1_out : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// Synchronous FIFO controller using an external dual-port RAM (port 0 push, port 1 pop).
// Latency: pop data one cycle after an accepted pop; RAM write at the end of the push cycle.
// Backpressure: push refused when full, pop refused when empty; refusals pulse wr_drop/rd_drop.
// Ports: clk, reset_n (sync, active-low), fifo (stream slave), ram_* (RAM port 0/1 controls).
module ram_dp_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_dp_fifo_ctrl_if.slave     fifo,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    inout  wire  [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    inout  wire  [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  rd_valid_q;
    logic                  wr_drop_q;
    logic                  rd_drop_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Flags decode the registered count, so a same-cycle pop never frees room
    // for a push when full; this keeps write and read addresses distinct.
    assign full  = (count_q == CW'(RAM_DEPTH));
    assign empty = (count_q == '0);
    assign push  = fifo.wr_en & ~full;
    assign pop   = fifo.rd_en & ~empty;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            rd_drop_q  <= 1'b0;
        end else begin
            count_q    <= count_q + CW'(push) - CW'(pop);
            rd_valid_q <= pop;
            wr_drop_q  <= fifo.wr_en & full;
            rd_drop_q  <= fifo.rd_en & empty;
        end
    end

    // Port 0: write-only, driven only in a cycle that actually pushes.
    assign ram_address_0 = wr_ptr;
    assign ram_cs_0      = push;
    assign ram_we_0      = push;
    assign ram_oe_0      = 1'b0;
    assign ram_data_0    = push ? fifo.wr_data : {DATA_WIDTH{1'bz}};

    // Port 1: parked in read mode on the head word; the RAM registers
    // mem[rd_ptr] at the pop edge and drives it during the following cycle.
    assign ram_address_1 = rd_ptr;
    assign ram_cs_1      = reset_n;
    assign ram_oe_1      = reset_n;
    assign ram_we_1      = 1'b0;

    assign fifo.rd_data  = ram_data_1;
    // A pop completing into a reset cycle is abandoned along with the RAM
    // read it launched, so the valid is masked rather than waiting an edge.
    assign fifo.rd_valid = rd_valid_q & reset_n;
    assign fifo.full     = full;
    assign fifo.empty    = empty;
    assign fifo.count    = count_q;
    assign fifo.wr_drop  = wr_drop_q;
    assign fifo.rd_drop  = rd_drop_q;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Scoreboard bench for ram_dp_fifo_ctrl (depth 4) driving a real ram_dp_sr_sw.
// Driver predicts per-cycle status and popped words from a queue model;
// a negedge monitor compares them against what the DUT presents.
module tb_ram_dp_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int due;
        int cnt;
        bit full;
        bit empty;
        bit wdrop;
        bit rdrop;
        bit rv;
        bit cs0;
        bit rn;
        int wa;
        int ra;
    } stat_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] ram_address_0;
    logic [AW-1:0] ram_address_1;
    wire  [DW-1:0] ram_data_0;
    wire  [DW-1:0] ram_data_1;
    logic          ram_cs_0, ram_we_0, ram_oe_0;
    logic          ram_cs_1, ram_we_1, ram_oe_1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Reference model state: the FIFO contents as a queue plus last-cycle pulses.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_data[$];
    stat_t         stq[$];
    bit            m_wdrop, m_rdrop, m_rv;
    int            m_wa, m_ra;
    stat_t         ms;

    ram_dp_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

    ram_dp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fifo          (fif),
        .ram_address_0 (ram_address_0),
        .ram_data_0    (ram_data_0),
        .ram_cs_0      (ram_cs_0),
        .ram_we_0      (ram_we_0),
        .ram_oe_0      (ram_oe_0),
        .ram_address_1 (ram_address_1),
        .ram_data_1    (ram_data_1),
        .ram_cs_1      (ram_cs_1),
        .ram_we_1      (ram_we_1),
        .ram_oe_1      (ram_oe_1)
    );

    ram_dp_sr_sw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .address_0 (ram_address_0),
        .data_0    (ram_data_0),
        .cs_0      (ram_cs_0),
        .we_0      (ram_we_0),
        .oe_0      (ram_oe_0),
        .address_1 (ram_address_1),
        .data_1    (ram_data_1),
        .cs_1      (ram_cs_1),
        .we_1      (ram_we_1),
        .oe_1      (ram_oe_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus. Registered outputs seen during this cycle
    // equal the model state before it is updated here.
    task automatic cycle(input bit rn, input bit w, input logic [DW-1:0] d, input bit r);
        stat_t s;
        bit    push, pop;
        reset_n     = rn;
        fif.wr_en   = w;
        fif.wr_data = d;
        fif.rd_en   = r;

        push = w && (mq.size() != DEPTH);
        pop  = r && (mq.size() != 0);

        s.due   = cyc;
        s.cnt   = mq.size();
        s.full  = (mq.size() == DEPTH);
        s.empty = (mq.size() == 0);
        s.wdrop = m_wdrop;
        s.rdrop = m_rdrop;
        s.rv    = m_rv && rn;
        s.cs0   = push;
        s.rn    = rn;
        s.wa    = m_wa;
        s.ra    = m_ra;
        stq.push_back(s);

        if (!rn) begin
            if (m_rv) void'(exp_data.pop_back());
            mq.delete();
            m_wdrop = 0;
            m_rdrop = 0;
            m_rv    = 0;
            m_wa    = 0;
            m_ra    = 0;
        end else begin
            m_wdrop = w && !push;
            m_rdrop = r && !pop;
            m_rv    = pop;
            if (pop) begin
                exp_data.push_back(mq.pop_front());
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (push) begin
                mq.push_back(d);
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: status every cycle, pop data whenever the DUT flags it valid.
    always @(negedge clk) begin
        if (stq.size() > 0 && stq[0].due == cyc) begin
            ms = stq.pop_front();
            check("count",    32'(fif.count),  32'(ms.cnt));
            check("full",     32'(fif.full),   32'(ms.full));
            check("empty",    32'(fif.empty),  32'(ms.empty));
            check("wr_drop",  32'(fif.wr_drop), 32'(ms.wdrop));
            check("rd_drop",  32'(fif.rd_drop), 32'(ms.rdrop));
            check("rd_valid", 32'(fif.rd_valid), 32'(ms.rv));
            check("ram_cs_0", 32'(ram_cs_0),   32'(ms.cs0));
            check("ram_we_0", 32'(ram_we_0),   32'(ms.cs0));
            check("ram_oe_0", 32'(ram_oe_0),   32'd0);
            check("ram_cs_1", 32'(ram_cs_1),   32'(ms.rn));
            check("ram_oe_1", 32'(ram_oe_1),   32'(ms.rn));
            check("ram_we_1", 32'(ram_we_1),   32'd0);
            if (ms.cs0) check("ram_address_0", 32'(ram_address_0), 32'(ms.wa));
            if (ms.rn)  check("ram_address_1", 32'(ram_address_1), 32'(ms.ra));
        end
        if (fif.rd_valid === 1'b1) begin
            if (exp_data.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_data", 32'(fif.rd_data), 32'(exp_data.pop_front()));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        fif.wr_en   = 1'b0;
        fif.wr_data = '0;
        fif.rd_en   = 1'b0;
        m_wdrop = 0; m_rdrop = 0; m_rv = 0; m_wa = 0; m_ra = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles.
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);

        // Fill to full, then one refused push.
        for (int i = 1; i <= 5; i++) cycle(1, 1, 8'(8'h11 * i), 0);
        cycle(1, 0, 8'h00, 0);

        // Drain, then one refused pop.
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);

        // Streaming across pointer wrap with occupancy 1-2.
        cycle(1, 1, 8'hA0, 0);
        for (int i = 1; i <= 9; i++) cycle(1, 1, 8'(8'hA0 + i), 1);
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);

        // Full with simultaneous push and pop: pop wins, push dropped.
        for (int i = 1; i <= 4; i++) cycle(1, 1, 8'(8'h60 + i), 0);
        cycle(1, 1, 8'h66, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);

        // Empty with simultaneous push and pop: push wins, pop dropped.
        cycle(1, 1, 8'h77, 1);
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);

        // Reset one cycle after a pop: the pending valid must not appear.
        cycle(1, 1, 8'h88, 0);
        cycle(1, 1, 8'h99, 0);
        cycle(1, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);

        // Randomized traffic in push-heavy / pop-heavy phases with rare resets.
        for (int ph = 0; ph < 10; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 75 : 30;
            for (int k = 0; k < 40; k++) begin
                bit rn, w, r;
                rn = ($urandom_range(0, 59) != 0);
                w  = rn && ($urandom_range(0, 99) < wp);
                r  = ($urandom_range(0, 99) < (100 - wp));
                cycle(rn, w, 8'($urandom), r);
            end
        end

        // Drain whatever is left.
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);

        check("pending_data", 32'(exp_data.size()), 32'd0);
        check("pending_status", 32'(stq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
